// File: rtl/rr_row_packer.sv
// rr_row_packer: packs a scalar element stream into wide memory rows.
// Collects no_of_units elements of element_width bits per row (lane 0 in
// the LSBs) and issues one write per row on the RR memory write port.
// Ports:
//   clk, reset_n (async, active-low)
//   start, base_address             : begin a new vector at base_address
//   in_valid, in_data, in_last      : element stream; in_ready = accept
//   write_enable/address/data       : one-cycle row write strobe
//   rows_written                    : rows committed since start
//   finish                          : one-cycle pulse after the last row
//   overflow (RR_PACKER_BOUNDS_CHECK_EN only) : sticky out-of-range flag
// Config macro RR_PACKER_BOUNDS_CHECK_EN: suppress writes whose row address
// is beyond max_row_address and flag them on overflow.
module rr_row_packer #(
    parameter int element_width   = 64,
    parameter int no_of_units     = 8,
    parameter int address_width   = 20,
    parameter int max_row_address = 1000
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic [address_width-1:0]             base_address,
    input  logic                                 in_valid,
    input  logic [element_width-1:0]             in_data,
    input  logic                                 in_last,
    output logic                                 in_ready,
    output logic                                 write_enable,
    output logic [address_width-1:0]             write_address,
    output logic [no_of_units*element_width-1:0] write_data,
    output logic [address_width-1:0]             rows_written,
    output logic                                 finish
`ifdef RR_PACKER_BOUNDS_CHECK_EN
    ,
    output logic                                 overflow
`endif
);

    localparam int row_width  = no_of_units * element_width;
    localparam int lane_width = (no_of_units > 1) ? $clog2(no_of_units) : 1;
    localparam logic [lane_width-1:0] last_lane =
        lane_width'(no_of_units - 1);
    localparam logic [address_width-1:0] max_addr =
        address_width'(max_row_address);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } state_t;

    state_t                   state;
    logic [lane_width-1:0]    lane_idx;
    logic [address_width-1:0] row_ptr;
    logic [row_width-1:0]     row_buf;
    logic [row_width-1:0]     row_next;
    logic                     last_flag;
    logic                     handshake;
    logic                     row_full;
    logic                     in_range;

    assign handshake = in_valid & in_ready;
    assign row_full  = (lane_idx == last_lane) | in_last;

    // Row buffer with the element being accepted merged in, so the write
    // strobe can carry the complete row on the very next cycle.
    always_comb begin
        row_next = row_buf;
        row_next[int'(lane_idx) * element_width +: element_width] = in_data;
    end

`ifdef RR_PACKER_BOUNDS_CHECK_EN
    assign in_range = (row_ptr <= max_addr);
`else
    logic unused_bound;
    assign unused_bound = ^max_addr;
    assign in_range     = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            rows_written  <= '0;
            finish        <= 1'b0;
            lane_idx      <= '0;
            row_ptr       <= '0;
            row_buf       <= '0;
            last_flag     <= 1'b0;
`ifdef RR_PACKER_BOUNDS_CHECK_EN
            overflow      <= 1'b0;
`endif
        end else begin
            write_enable <= 1'b0;
            finish       <= 1'b0;

            unique case (state)
                IDLE: begin
                end
                FILL: begin
                    if (handshake) begin
                        lane_idx <= lane_idx + 1'b1;
                        row_buf  <= row_next;
                        if (row_full) begin
                            state         <= WRITE;
                            in_ready      <= 1'b0;
                            write_enable  <= in_range;
                            write_address <= row_ptr;
                            write_data    <= row_next;
                            last_flag     <= in_last;
`ifdef RR_PACKER_BOUNDS_CHECK_EN
                            if (!in_range) overflow <= 1'b1;
`endif
                        end
                    end
                end
                WRITE: begin
                    row_ptr      <= row_ptr + 1'b1;
                    rows_written <= rows_written + 1'b1;
                    lane_idx     <= '0;
                    row_buf      <= '0;
                    if (last_flag) begin
                        state  <= DONE;
                        finish <= 1'b1;
                    end else begin
                        state    <= FILL;
                        in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // start wins in every state: it aborts any partial row and any
            // pending finish. A write already on the port this cycle still
            // completes because the strobe was registered last cycle.
            if (start) begin
                state        <= FILL;
                in_ready     <= 1'b1;
                write_enable <= 1'b0;
                finish       <= 1'b0;
                row_ptr      <= base_address;
                rows_written <= '0;
                lane_idx     <= '0;
                row_buf      <= '0;
                last_flag    <= 1'b0;
`ifdef RR_PACKER_BOUNDS_CHECK_EN
                overflow     <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_rr_row_packer.sv
// tb_rr_row_packer: randomized self-checking bench for rr_row_packer.
// Expected rows come from a chunk-and-pack model of the element stream.
module tb_rr_row_packer;

    localparam int EW = 64;
    localparam int NU = 8;
    localparam int AW = 20;
    localparam int RW = NU * EW;
    localparam int MAXA = 1000;
`ifdef RR_PACKER_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_address = '0;
    logic          in_valid = 1'b0;
    logic [EW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          write_enable;
    logic [AW-1:0] write_address;
    logic [RW-1:0] write_data;
    logic [AW-1:0] rows_written;
    logic          finish;
`ifdef RR_PACKER_BOUNDS_CHECK_EN
    logic          overflow;
`endif

    rr_row_packer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .base_address (base_address),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .write_enable (write_enable),
        .write_address(write_address),
        .write_data   (write_data),
        .rows_written (rows_written),
        .finish       (finish)
`ifdef RR_PACKER_BOUNDS_CHECK_EN
        ,
        .overflow     (overflow)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    int fin_cnt = 0;
    int fin_cyc = -1;

    logic [AW-1:0] got_addr[$];
    logic [RW-1:0] got_data[$];
    int            got_cyc[$];
    int            hs_cyc[$];
    logic [AW-1:0] exp_addr[$];
    logic [RW-1:0] exp_data[$];
    logic [EW-1:0] elems[$];

    // Advance one cycle, observe 1ns after the edge and log writes/finish.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (write_enable === 1'b1) begin
            got_addr.push_back(write_address);
            got_data.push_back(write_data);
            got_cyc.push_back(cyc);
        end
        if (finish === 1'b1) begin
            fin_cnt++;
            fin_cyc = cyc;
        end
    endtask

    // Reference: chop the element list into rows of NU, zero-fill the tail,
    // rows go to consecutive addresses (mod 2^AW), out-of-range dropped
    // when bounds checking is built in.
    task automatic build_expected(input logic [AW-1:0] base);
        int n;
        int nrows;
        logic [RW-1:0] row;
        logic [AW-1:0] a;
        n = elems.size();
        nrows = (n + NU - 1) / NU;
        exp_addr.delete();
        exp_data.delete();
        for (int r = 0; r < nrows; r++) begin
            row = '0;
            for (int l = 0; l < NU; l++)
                if (r * NU + l < n) row[l*EW +: EW] = elems[r*NU + l];
            a = base + AW'(r);
            if (!BOUNDS || a <= AW'(MAXA)) begin
                exp_addr.push_back(a);
                exp_data.push_back(row);
            end
        end
    endtask

    // Start a vector and stream elems with random valid gaps.
    task automatic run_vector(input logic [AW-1:0] base, input int gap_pct,
                              input bit with_last);
        int idx;
        int budget;
        bit hs;
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
        hs_cyc.delete();
        fin_cnt = 0;
        fin_cyc = -1;
        start = 1'b1;
        base_address = base;
        tick();
        start = 1'b0;
        idx = 0;
        budget = 4000;
        while (idx < elems.size() && budget > 0) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data = elems[idx];
            in_last = with_last && (idx == elems.size() - 1);
            hs = in_valid && in_ready;
            if (hs) hs_cyc.push_back(cyc);
            tick();
            if (hs) idx++;
            budget--;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        if (with_last) begin
            budget = 20;
            while (fin_cnt == 0 && budget > 0) begin
                tick();
                budget--;
            end
            tick();
            tick();
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #2;
        vectors++;
        if ({in_ready, write_enable, finish} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl: got %b, expected 000",
                     {in_ready, write_enable, finish});
        end
        vectors++;
        if ({write_address, rows_written} !== '0) begin
            errors++;
            $display("FAIL reset_cnt: got %0h/%0h, expected 0/0",
                     write_address, rows_written);
        end
        vectors++;
        if (write_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %0h, expected 0", write_data);
        end
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        vectors++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got %b, expected 0", in_ready);
        end
    endtask

    task automatic test_two_rows();
        elems.delete();
        for (int i = 1; i <= 16; i++) elems.push_back(EW'(i));
        run_vector(AW'(10), 0, 1'b1);
        build_expected(AW'(10));
        vectors++;
        if (got_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL two_rows_count: got %0d, expected %0d",
                     got_addr.size(), exp_addr.size());
        end else begin
            for (int r = 0; r < exp_addr.size(); r++) begin
                vectors++;
                if (got_addr[r] !== exp_addr[r] ||
                    got_data[r] !== exp_data[r]) begin
                    errors++;
                    $display("FAIL two_rows[%0d]: got @%0h %0h, expected @%0h %0h",
                             r, got_addr[r], got_data[r], exp_addr[r], exp_data[r]);
                end
            end
            vectors++;
            if (fin_cyc != got_cyc[got_cyc.size()-1] + 1) begin
                errors++;
                $display("FAIL finish_timing: got cycle %0d, expected %0d",
                         fin_cyc, got_cyc[got_cyc.size()-1] + 1);
            end
        end
        vectors++;
        if (rows_written !== AW'(2) || fin_cnt != 1) begin
            errors++;
            $display("FAIL two_rows_done: got rows %0d fin %0d, expected 2/1",
                     rows_written, fin_cnt);
        end
    endtask

    task automatic test_partial();
        elems.delete();
        for (int i = 0; i < 3; i++) elems.push_back({$urandom, $urandom});
        run_vector(AW'(0), 0, 1'b1);
        build_expected(AW'(0));
        vectors++;
        if (got_addr.size() != 1 || fin_cnt != 1) begin
            errors++;
            $display("FAIL partial_count: got %0d writes fin %0d, expected 1/1",
                     got_addr.size(), fin_cnt);
        end else begin
            vectors++;
            if (got_addr[0] !== exp_addr[0] || got_data[0] !== exp_data[0]) begin
                errors++;
                $display("FAIL partial_row: got @%0h %0h, expected @%0h %0h",
                         got_addr[0], got_data[0], exp_addr[0], exp_data[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int exp_d;
        elems.delete();
        for (int i = 0; i < 3 * NU; i++) elems.push_back({$urandom, $urandom});
        run_vector(AW'(100), 0, 1'b1);
        vectors++;
        if (hs_cyc.size() != 3 * NU || got_cyc.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d hs %0d writes, expected %0d/3",
                     hs_cyc.size(), got_cyc.size(), 3 * NU);
        end else begin
            for (int i = 1; i < 3 * NU; i++) begin
                exp_d = (i % NU == 0) ? 2 : 1;
                vectors++;
                if (hs_cyc[i] - hs_cyc[i-1] != exp_d) begin
                    errors++;
                    $display("FAIL b2b_gap[%0d]: got %0d, expected %0d",
                             i, hs_cyc[i] - hs_cyc[i-1], exp_d);
                end
            end
            for (int r = 0; r < 3; r++) begin
                vectors++;
                if (got_cyc[r] != hs_cyc[r*NU + NU - 1] + 1) begin
                    errors++;
                    $display("FAIL b2b_wr_lat[%0d]: got %0d, expected %0d",
                             r, got_cyc[r], hs_cyc[r*NU + NU - 1] + 1);
                end
            end
        end
    endtask

    task automatic test_abort();
        elems.delete();
        for (int i = 0; i < 5; i++) elems.push_back({$urandom, $urandom});
        run_vector(AW'(30), 0, 1'b0);
        vectors++;
        if (got_addr.size() != 0) begin
            errors++;
            $display("FAIL abort_nowrite: got %0d writes, expected 0",
                     got_addr.size());
        end
        elems.delete();
        for (int i = 0; i < NU; i++) elems.push_back({$urandom, $urandom});
        run_vector(AW'(20), 30, 1'b1);
        build_expected(AW'(20));
        vectors++;
        if (got_addr.size() != 1 || fin_cnt != 1) begin
            errors++;
            $display("FAIL abort_restart: got %0d writes fin %0d, expected 1/1",
                     got_addr.size(), fin_cnt);
        end else begin
            vectors++;
            if (got_addr[0] !== exp_addr[0] || got_data[0] !== exp_data[0]) begin
                errors++;
                $display("FAIL abort_row: got @%0h %0h, expected @%0h %0h",
                         got_addr[0], got_data[0], exp_addr[0], exp_data[0]);
            end
        end
    endtask

    task automatic test_start_in_done();
        start = 1'b1;
        base_address = AW'(60);
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 64'h1111;
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
        tick();
        vectors++;
        if (finish !== 1'b1) begin
            errors++;
            $display("FAIL done_finish: got %b, expected 1", finish);
        end
        start = 1'b1;
        base_address = AW'(70);
        tick();
        start = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || finish !== 1'b0) begin
            errors++;
            $display("FAIL done_restart: got ready %b fin %b, expected 1/0",
                     in_ready, finish);
        end
        in_valid = 1'b1;
        in_data = 64'h2222;
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
        vectors++;
        if (write_enable !== 1'b1 || write_address !== AW'(70)) begin
            errors++;
            $display("FAIL done_newvec: got we %b @%0h, expected 1 @46",
                     write_enable, write_address);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_fill();
        elems.delete();
        for (int i = 0; i < 5; i++) elems.push_back({$urandom, $urandom});
        run_vector(AW'(40), 0, 1'b0);
        got_addr.delete();
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, write_enable, finish} !== 3'b000 ||
            write_data !== '0 || write_address !== '0 ||
            rows_written !== '0) begin
            errors++;
            $display("FAIL async_reset: got ready %b we %b fin %b data %0h",
                     in_ready, write_enable, finish, write_data);
        end
        #1 reset_n = 1'b1;
        in_valid = 1'b1;
        in_last = 1'b1;
        repeat (12) tick();
        in_valid = 1'b0;
        in_last = 1'b0;
        vectors++;
        if (got_addr.size() != 0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got %0d writes ready %b, expected 0/0",
                     got_addr.size(), in_ready);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] base;
        int n;
        for (int v = 0; v < 25; v++) begin
            n = $urandom_range(1, 20);
            elems.delete();
            for (int i = 0; i < n; i++) elems.push_back({$urandom, $urandom});
            if (v % 3 == 0) base = AW'($urandom_range(0, MAXA));
            else base = AW'($urandom);
            run_vector(base, $urandom_range(0, 50), 1'b1);
            build_expected(base);
            vectors++;
            if (got_addr.size() != exp_addr.size() || fin_cnt != 1 ||
                rows_written !== AW'((n + NU - 1) / NU)) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d writes fin %0d rows %0d, expected %0d/1/%0d",
                         v, got_addr.size(), fin_cnt, rows_written,
                         exp_addr.size(), (n + NU - 1) / NU);
            end else begin
                for (int r = 0; r < exp_addr.size(); r++) begin
                    vectors++;
                    if (got_addr[r] !== exp_addr[r] ||
                        got_data[r] !== exp_data[r]) begin
                        errors++;
                        $display("FAIL rand%0d_row%0d: got @%0h %0h, expected @%0h %0h",
                                 v, r, got_addr[r], got_data[r],
                                 exp_addr[r], exp_data[r]);
                    end
                end
            end
        end
    endtask

    task automatic test_bounds();
        elems.delete();
        for (int i = 0; i < 2 * NU; i++) elems.push_back({$urandom, $urandom});
        run_vector(AW'(MAXA), 0, 1'b1);
        build_expected(AW'(MAXA));
        vectors++;
        if (got_addr.size() != exp_addr.size() || fin_cnt != 1 ||
            rows_written !== AW'(2)) begin
            errors++;
            $display("FAIL bounds_count: got %0d writes fin %0d rows %0d, expected %0d/1/2",
                     got_addr.size(), fin_cnt, rows_written, exp_addr.size());
        end else begin
            for (int r = 0; r < exp_addr.size(); r++) begin
                vectors++;
                if (got_addr[r] !== exp_addr[r] ||
                    got_data[r] !== exp_data[r]) begin
                    errors++;
                    $display("FAIL bounds_row%0d: got @%0h, expected @%0h",
                             r, got_addr[r], exp_addr[r]);
                end
            end
        end
`ifdef RR_PACKER_BOUNDS_CHECK_EN
        vectors++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL bounds_overflow: got %b, expected 1", overflow);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_two_rows();
        test_partial();
        test_back_to_back();
        test_abort();
        test_start_in_done();
        test_reset_mid_fill();
        test_random();
        test_bounds();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
